// File: rtl/minc_pkg.sv
// rtl/minc_pkg.sv - shared constants and state type for the minc instruction-ROM loader
package minc_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    localparam int         INSTR_W     = 15;
    localparam int         ADDR_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/minc_loader.sv
// rtl/minc_loader.sv - byte-stream loader for the minc instruction ROM; holds the core in reset until loaded
// Optional trailing checksum byte and check enabled by defining MINC_LOADER_CSUM_EN.
module minc_loader
    import minc_pkg::*;
(
    input  logic               CLK,
    input  logic               nRESET,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               rom_we,
    output logic [ADDR_W-1:0]  rom_waddr,
    output logic [INSTR_W-1:0] rom_wdata,
    output logic               cpu_nreset,
    output logic               done,
    output logic               error
);

    loader_state_t      state_q;
    logic               rx_ready_q;
    logic               rom_we_q;
    logic [ADDR_W-1:0]  rom_waddr_q;
    logic [INSTR_W-1:0] rom_wdata_q;
    logic               cpu_nreset_q;
    logic               done_q;
    logic               error_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [8:0]         cnt_q;
    logic [INSTR_W-9:0] hi_q;
`ifdef MINC_LOADER_CSUM_EN
    logic [7:0]         csum_q;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= ST_IDLE;
            rx_ready_q   <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_waddr_q  <= '0;
            rom_wdata_q  <= '0;
            cpu_nreset_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            hi_q         <= '0;
`ifdef MINC_LOADER_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            rom_we_q <= 1'b0;
            // Only IDLE can follow reset with rx_ready low; every exit to DONE/ERR clears it below.
            if (state_q == ST_IDLE) begin
                rx_ready_q <= 1'b1;
            end
            if (rx_ready_q && rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == LOADER_SYNC) begin
                            state_q <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        cnt_q   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        addr_q  <= '0;
`ifdef MINC_LOADER_CSUM_EN
                        csum_q  <= '0;
`endif
                        state_q <= ST_HI;
                    end
                    ST_HI: begin
                        if (rx_data[7]) begin
                            state_q    <= ST_ERR;
                            error_q    <= 1'b1;
                            rx_ready_q <= 1'b0;
                        end else begin
                            hi_q    <= rx_data[INSTR_W-9:0];
`ifdef MINC_LOADER_CSUM_EN
                            csum_q  <= csum_q + rx_data;
`endif
                            state_q <= ST_LO;
                        end
                    end
                    ST_LO: begin
                        rom_we_q    <= 1'b1;
                        rom_waddr_q <= addr_q;
                        rom_wdata_q <= {hi_q, rx_data};
                        addr_q      <= addr_q + 8'd1;
                        cnt_q       <= cnt_q - 9'd1;
`ifdef MINC_LOADER_CSUM_EN
                        csum_q      <= csum_q + rx_data;
`endif
                        if (cnt_q == 9'd1) begin
`ifdef MINC_LOADER_CSUM_EN
                            state_q      <= ST_CSUM;
`else
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            cpu_nreset_q <= 1'b1;
                            rx_ready_q   <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_HI;
                        end
                    end
`ifdef MINC_LOADER_CSUM_EN
                    ST_CSUM: begin
                        rx_ready_q <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            cpu_nreset_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_ready   = rx_ready_q;
    assign rom_we     = rom_we_q;
    assign rom_waddr  = rom_waddr_q;
    assign rom_wdata  = rom_wdata_q;
    assign cpu_nreset = cpu_nreset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: doc/minc_loader.md
MINC_LOADER -- requirements
Module: minc_loader

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port nRESET, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rx_data, input, 8, incoming byte from the host link.
REQ-004 SHALL have port rx_valid, input, 1, rx_data holds a byte.
REQ-005 SHALL have port rx_ready, output, 1, loader accepts a byte; transfer occurs when rx_valid and rx_ready are both 1 on a rising edge.
REQ-006 SHALL have port rom_we, output, 1, one-cycle instruction-ROM write strobe.
REQ-007 SHALL have port rom_waddr, output, 8, ROM word address.
REQ-008 SHALL have port rom_wdata, output, 15, instruction word.
REQ-009 SHALL have port cpu_nreset, output, 1, active-low hold for the core; 0 until a load completes.
REQ-010 SHALL have port done, output, 1, load completed successfully.
REQ-011 SHALL have port error, output, 1, load aborted on a protocol or checksum fault.

Function
REQ-012 SHALL accept the frame SYNC (8'hA5), COUNT N, N word pairs (HI then LO), then CSUM.
- HI carries bits 14:8 in its bits 6:0.
- LO carries bits 7:0.
- N=0 means 256 words.
REQ-013 SHALL implement the states IDLE, COUNT, HI, LO, CSUM, DONE and ERR.
REQ-014 SHALL drive rx_ready=1 in IDLE, COUNT, HI, LO and CSUM, and rx_ready=0 in DONE and ERR.
REQ-015 IDLE SHALL consume and discard any byte other than 8'hA5; on 8'hA5 it SHALL go to COUNT.
REQ-016 COUNT SHALL latch N into a 9-bit remaining-word counter (0 loads 256), clear the word address and checksum, and go to HI.
REQ-017 A HI byte with bit 7 = 1 SHALL cause a transition to ERR with no ROM write.
REQ-018 On a LO handshake, the loader SHALL assert rom_we for exactly one cycle on the following cycle, with rom_waddr and rom_wdata registered and stable during that cycle.
REQ-019 After each write, the word address SHALL increment with 8-bit wrap, and the counter SHALL decrement.
REQ-020 After the write that brings the counter to 0, the loader SHALL go to CSUM; otherwise it SHALL go to HI.
REQ-021 The checksum SHALL be the 8-bit modulo-256 sum of all HI and LO bytes; SYNC and COUNT are excluded.
REQ-022 In CSUM, a matching byte SHALL cause a transition to DONE and a mismatch SHALL cause a transition to ERR.
REQ-023 In DONE, the loader SHALL drive done=1 and cpu_nreset=1, both registered and asserted on the cycle after the final handshake.
REQ-024 In ERR, the loader SHALL drive error=1 and cpu_nreset=0.
REQ-025 DONE and ERR SHALL be sticky until nRESET.
REQ-026 When rx_ready=0, rx_valid SHALL be ignored with no state change.
REQ-027 A byte handshake during the rom_we cycle SHALL be accepted normally; back-to-back bytes SHALL sustain one byte per cycle with no stall.

Reset
REQ-028 While nRESET=0, the loader SHALL force state IDLE and drive rom_we=0, rom_waddr=0, rom_wdata=0, cpu_nreset=0, done=0, error=0 and rx_ready=0.
REQ-029 rx_ready SHALL rise on the first clock after nRESET deasserts.
REQ-030 Reset mid-load SHALL abort the frame without emitting a partial write; words already written remain in ROM.

Configuration
REQ-031 With MINC_LOADER_CSUM_EN defined, the CSUM state and the check SHALL be present.
REQ-032 With MINC_LOADER_CSUM_EN undefined, the loader SHALL go to DONE directly after the last write, remove the checksum register, expect no CSUM byte, and treat any further byte as not accepted (rx_ready=0).

Structure
REQ-033 Package minc_pkg SHALL hold LOADER_SYNC (8'hA5), INSTR_W (15), ADDR_W (8) and the loader state enum type.
REQ-034 The loader SHALL be a single module with no sub-module; the checksum accumulator and counters are inline.

Verification
REQ-035 The bench SHALL send A5 02 01 23 00 45 69 -> writes 15'h0123 at 0 and 15'h0045 at 1, then done=1 and cpu_nreset=1 one cycle after the last byte.
REQ-036 The bench SHALL send A5 01 80 00 -> error=1, no rom_we, and rx_ready=0 thereafter.
REQ-037 The bench SHALL send A5 01 00 07 00 (CSUM_EN) -> one write of 15'h0007 at 0, then error=1 and done=0.
REQ-038 The bench SHALL send 3C 11 A5 00 followed by 256 pairs 00 xx -> leading bytes discarded, 256 writes at addresses 0..255, and done only after the final CSUM.
REQ-039 The bench SHALL pulse nRESET low after the HI byte of word 3 -> all outputs return to reset values, and a fresh frame then loads from address 0.
REQ-040 The bench SHALL hold rx_valid=1 continuously with random rx_valid gaps in a second run -> identical ROM contents and a single rom_we per word.
